// File: rtl/plru_alloc_pkg.sv
// Shared types for the PLRU entry allocator.
package plru_alloc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        RESP   = 2'd2,
        FLUSH  = 2'd3
    } state_e;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU over ENTRIES leaves: one-hot touch in, one-hot victim out.
module plru_tree #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [ENTRIES-1:0] used_i,
    output logic [ENTRIES-1:0] plru_o
);
    localparam int unsigned IdxW  = $clog2(ENTRIES);
    localparam int unsigned NodeN = ENTRIES - 1;

    // Heap-ordered node bits: 0 = victim in left subtree, 1 = victim in right subtree.
    logic [NodeN-1:0] node_q, node_d;
    logic [IdxW-1:0]  vict;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            node_q <= '0;
        end else begin
            node_q <= node_d;
        end
    end

    // Every node on the touched leaf's path is pointed at the other subtree.
    always_comb begin
        node_d = node_q;
        for (int unsigned e = 0; e < ENTRIES; e++) begin
            if (used_i[e]) begin
                for (int unsigned l = 0; l < IdxW; l++) begin
                    node_d[(32'd1 << l) - 32'd1 + (e >> (IdxW - l))] =
                        ((e >> (IdxW - 32'd1 - l)) & 32'd1) == 32'd0;
                end
            end
        end
    end

    always_comb begin
        int unsigned n;
        n    = 0;
        vict = '0;
        for (int unsigned l = 0; l < IdxW; l++) begin
            vict[IdxW - 32'd1 - l] = node_q[n];
            n = 2 * n + 1 + 32'(node_q[n]);
        end
        plru_o = ENTRIES'(1) << vict;
    end

endmodule

// File: rtl/plru_alloc_ctrl.sv
// Round-robin entry allocator: invalid-first, PLRU victim otherwise, with invalidate/flush.
module plru_alloc_ctrl
    import plru_alloc_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned NumReq  = 4,
    localparam int unsigned IdxW   = $clog2(ENTRIES),
    localparam int unsigned ReqIdW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NumReq-1:0]  req_valid_i,
    output logic [NumReq-1:0]  req_ready_o,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [ReqIdW-1:0]  rsp_id_o,
    output logic [IdxW-1:0]    rsp_idx_o,
    output logic               rsp_evict_o,
    input  logic               hit_valid_i,
    input  logic [IdxW-1:0]    hit_idx_i,
    input  logic               inval_i,
    input  logic [IdxW-1:0]    inval_idx_i,
    input  logic               flush_i,
    output logic               flush_busy_o,
    output logic [ENTRIES-1:0] valid_o
);
    state_e              state_q, state_d;
    logic [ReqIdW-1:0]   rr_q, rr_d, id_q, id_d, win;
    logic [IdxW-1:0]     idx_q, idx_d, free_idx, plru_idx, victim;
    logic                evict_q, evict_d, pend_q, pend_d;
    logic                any_req, any_free, grant;
    logic [ENTRIES-1:0]  valid_q, valid_d, used, plru_vec;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            idx_q   <= '0;
            evict_q <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            evict_q <= evict_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
        end
    end

    // Round-robin winner: first requester at or after the pointer.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!any_req && req_valid_i[(32'(rr_q) + k) % NumReq]) begin
                any_req = 1'b1;
                win     = ReqIdW'((32'(rr_q) + k) % NumReq);
            end
        end
    end

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        plru_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!any_free && !valid_q[i]) begin
                any_free = 1'b1;
                free_idx = IdxW'(i);
            end
            if (plru_vec[i]) begin
                plru_idx = plru_idx | IdxW'(i);
            end
        end
        victim = any_free ? free_idx : plru_idx;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = FLUSH;
                end else if (any_req) begin
                    state_d = SELECT;
                end
            end
            SELECT:  state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant        = (state_q == IDLE) && !pend_q && any_req;
        req_ready_o  = '0;
        if (grant) begin
            req_ready_o[win] = 1'b1;
        end
        rsp_valid_o  = (state_q == RESP);
        flush_busy_o = pend_q || (state_q == FLUSH);
        rsp_id_o     = id_q;
        rsp_idx_o    = idx_q;
        rsp_evict_o  = evict_q;
        valid_o      = valid_q;
    end

    // Datapath updates; a SELECT set beats a same-cycle invalidate, and SELECT's touch beats a hit.
    always_comb begin
        rr_d    = rr_q;
        id_d    = id_q;
        idx_d   = idx_q;
        evict_d = evict_q;
        valid_d = valid_q;
        pend_d  = pend_q || flush_i;
        used    = '0;
        if (grant) begin
            id_d = win;
            rr_d = ReqIdW'((32'(win) + 32'd1) % NumReq);
        end
        if (state_q == FLUSH) begin
            valid_d = '0;
            pend_d  = flush_i;
        end
        if (inval_i) begin
            valid_d[inval_idx_i] = 1'b0;
        end
        if (state_q == SELECT) begin
            idx_d           = victim;
            evict_d         = valid_q[victim];
            valid_d[victim] = 1'b1;
            used[victim]    = 1'b1;
        end else if (hit_valid_i) begin
            used[hit_idx_i] = 1'b1;
        end
    end

    plru_tree #(
        .ENTRIES (ENTRIES)
    ) u_plru_tree (
        .clk_i  (clk_i),
        .rst_ni (~rst_i),
        .used_i (used),
        .plru_o (plru_vec)
    );

endmodule

// File: tb/tb_plru_alloc_ctrl.sv
// Self-checking bench for plru_alloc_ctrl against a timestamp-based tree-PLRU model.
module tb_plru_alloc_ctrl;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic [3:0] idx;
        logic       ev;
        logic       tmo;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready_o;
    logic        rsp_valid_o;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id_o;
    logic [3:0]  rsp_idx_o;
    logic        rsp_evict_o;
    logic        hit_valid = 1'b0;
    logic [3:0]  hit_idx = '0;
    logic        inval = 1'b0;
    logic [3:0]  inval_idx = '0;
    logic        flush_i = 1'b0;
    logic        flush_busy_o;
    logic [15:0] valid_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: valid bits, last-touch timestamps, round-robin pointer.
    bit [15:0]   m_val;
    int unsigned m_ts [16];
    int unsigned m_now;
    int          m_rr;

    always #5 clk = ~clk;

    plru_alloc_ctrl #(.ENTRIES(16), .NumReq(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id_o),
        .rsp_idx_o    (rsp_idx_o),
        .rsp_evict_o  (rsp_evict_o),
        .hit_valid_i  (hit_valid),
        .hit_idx_i    (hit_idx),
        .inval_i      (inval),
        .inval_idx_i  (inval_idx),
        .flush_i      (flush_i),
        .flush_busy_o (flush_busy_o),
        .valid_o      (valid_o)
    );

    function automatic void m_reset();
        m_val = '0;
        m_now = 0;
        m_rr  = 0;
        for (int i = 0; i < 16; i++) m_ts[i] = 0;
    endfunction

    function automatic void m_touch(input int e);
        m_now++;
        m_ts[e] = m_now;
    endfunction

    // Lowest invalid entry, else descend away from the half holding the most recent touch.
    function automatic int m_victim();
        int lo, size, half;
        int unsigned ml, mr;
        for (int i = 0; i < 16; i++) if (!m_val[i]) return i;
        lo = 0;
        size = 16;
        while (size > 1) begin
            half = size / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < half; i++) begin
                if (m_ts[lo + i] > ml) ml = m_ts[lo + i];
                if (m_ts[lo + half + i] > mr) mr = m_ts[lo + half + i];
            end
            if (ml > mr) lo += half;
            size = half;
        end
        return lo;
    endfunction

    function automatic txn_t m_step(input logic [3:0] mask);
        txn_t t;
        int w, v;
        w = -1;
        for (int k = 0; k < 4; k++) if (w < 0 && mask[(m_rr + k) % 4]) w = (m_rr + k) % 4;
        m_rr = (w + 1) % 4;
        v = m_victim();
        t.gnt = 4'(1 << w);
        t.id  = 2'(w);
        t.idx = 4'(v);
        t.ev  = m_val[v];
        t.tmo = 1'b0;
        m_val[v] = 1'b1;
        m_touch(v);
        return t;
    endfunction

    task automatic do_alloc(input logic [3:0] mask, input int stall, input bit sel_hit,
                            input logic [3:0] sel_hit_idx, input bit do_flush,
                            output txn_t obs, output bit lat_ok, output bit stable_ok,
                            output bit busy_seen);
        int cyc;
        obs = '0;
        lat_ok = 1'b0;
        stable_ok = 1'b0;
        busy_seen = 1'b0;
        cyc = 0;
        req_valid = mask;
        #1;
        while (req_ready_o === 4'b0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (req_ready_o === 4'b0) begin
            obs.tmo = 1'b1;
            req_valid = '0;
            return;
        end
        obs.gnt = req_ready_o;
        @(posedge clk); #1;
        req_valid = '0;
        hit_valid = sel_hit;
        hit_idx = sel_hit_idx;
        lat_ok = (rsp_valid_o === 1'b0);
        @(posedge clk); #1;
        hit_valid = 1'b0;
        lat_ok = lat_ok && (rsp_valid_o === 1'b1);
        obs.id = rsp_id_o;
        obs.idx = rsp_idx_o;
        obs.ev = rsp_evict_o;
        stable_ok = 1'b1;
        for (int k = 0; k < stall; k++) begin
            if (do_flush && k == 0) flush_i = 1'b1;
            @(posedge clk); #1;
            flush_i = 1'b0;
            if (rsp_valid_o !== 1'b1 || {rsp_id_o, rsp_idx_o, rsp_evict_o} !== {obs.id, obs.idx, obs.ev})
                stable_ok = 1'b0;
        end
        busy_seen = flush_busy_o;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({req_ready_o, rsp_valid_o, rsp_id_o, rsp_idx_o, rsp_evict_o, flush_busy_o, valid_o} !== 29'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b id=%0d idx=%0d ev=%b busy=%b valid=%h, want all 0",
                     req_ready_o, rsp_valid_o, rsp_id_o, rsp_idx_o, rsp_evict_o, flush_busy_o, valid_o);
        end
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_fill();
        txn_t exp, obs;
        bit lat, stab, busy, lat_all;
        lat_all = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = m_step(4'b0001);
            do_alloc(4'b0001, 0, 1'b0, 4'd0, 1'b0, obs, lat, stab, busy);
            lat_all = lat_all && lat;
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL fill[%0d]: got %b want %b", i, obs, exp);
            end
        end
        n_cmp++;
        if (lat_all !== 1'b1) begin
            n_err++;
            $display("FAIL fill_latency: got %b want 1", lat_all);
        end
        n_cmp++;
        if (valid_o !== m_val) begin
            n_err++;
            $display("FAIL fill_valid: got %h want %h", valid_o, m_val);
        end
    endtask

    task automatic test_plru_evict();
        txn_t exp, obs;
        bit lat, stab, busy;
        for (int i = 0; i < 2; i++) begin
            exp = m_step(4'b0001);
            do_alloc(4'b0001, 0, 1'b0, 4'd0, 1'b0, obs, lat, stab, busy);
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL plru_evict[%0d]: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back_rr();
        txn_t exp, obs;
        bit lat, stab, busy;
        for (int i = 0; i < 5; i++) begin
            exp = m_step(4'b1111);
            do_alloc(4'b1111, 3, 1'b0, 4'd0, 1'b0, obs, lat, stab, busy);
            n_cmp++;
            if (obs !== exp || stab !== 1'b1) begin
                n_err++;
                $display("FAIL rr[%0d]: got %b stable=%b want %b stable=1", i, obs, stab, exp);
            end
        end
    endtask

    task automatic test_inval_hit();
        txn_t exp, obs;
        bit lat, stab, busy;
        inval = 1'b1;
        inval_idx = 4'd5;
        @(posedge clk); #1;
        inval = 1'b0;
        m_val[5] = 1'b0;
        n_cmp++;
        if (valid_o !== m_val) begin
            n_err++;
            $display("FAIL inval_valid: got %h want %h", valid_o, m_val);
        end
        for (int i = 0; i < 3; i++) begin
            exp = m_step(4'b0100);
            do_alloc(4'b0100, 0, (i == 1), 4'd3, 1'b0, obs, lat, stab, busy);
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL inval_hit[%0d]: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_flush();
        txn_t exp, obs;
        bit lat, stab, busy;
        exp = m_step(4'b0010);
        do_alloc(4'b0010, 2, 1'b0, 4'd0, 1'b1, obs, lat, stab, busy);
        n_cmp++;
        if (obs !== exp || busy !== 1'b1) begin
            n_err++;
            $display("FAIL flush_resp: got %b busy=%b want %b busy=1", obs, busy, exp);
        end
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if ({flush_busy_o, req_ready_o} !== 5'b10000) begin
            n_err++;
            $display("FAIL flush_pending_nogrant: got busy=%b rdy=%b want busy=1 rdy=0000", flush_busy_o, req_ready_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({flush_busy_o, req_ready_o} !== 5'b10000) begin
            n_err++;
            $display("FAIL flush_exec_nogrant: got busy=%b rdy=%b want busy=1 rdy=0000", flush_busy_o, req_ready_o);
        end
        @(posedge clk); #1;
        m_val = '0;
        n_cmp++;
        if ({flush_busy_o, valid_o} !== 17'b0) begin
            n_err++;
            $display("FAIL flush_done: got busy=%b valid=%h want busy=0 valid=0", flush_busy_o, valid_o);
        end
        exp = m_step(4'b0001);
        do_alloc(4'b0001, 0, 1'b0, 4'd0, 1'b0, obs, lat, stab, busy);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL flush_next_alloc: got %b want %b", obs, exp);
        end
    endtask

    task automatic test_random();
        txn_t exp, obs;
        bit lat, stab, busy;
        logic [3:0] mask;
        int r;
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 2)) begin
                r = $urandom_range(0, 15);
                if ($urandom_range(0, 1) == 1) begin
                    hit_valid = 1'b1;
                    hit_idx = 4'(r);
                    m_touch(r);
                end else begin
                    inval = 1'b1;
                    inval_idx = 4'(r);
                    m_val[r] = 1'b0;
                end
                @(posedge clk); #1;
                hit_valid = 1'b0;
                inval = 1'b0;
            end
            n_cmp++;
            if (valid_o !== m_val) begin
                n_err++;
                $display("FAIL rand_valid[%0d]: got %h want %h", it, valid_o, m_val);
            end
            mask = 4'($urandom_range(1, 15));
            exp = m_step(mask);
            do_alloc(mask, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     1'b0, obs, lat, stab, busy);
            n_cmp++;
            if (obs !== exp || stab !== 1'b1) begin
                n_err++;
                $display("FAIL rand_alloc[%0d]: got %b stable=%b want %b stable=1", it, obs, stab, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        txn_t exp, obs;
        bit lat, stab, busy;
        int cyc;
        cyc = 0;
        req_valid = 4'b0001;
        #1;
        while (req_ready_o === 4'b0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (req_ready_o !== 4'b0001) begin
            n_err++;
            $display("FAIL rstmid_grant: got %b want 0001", req_ready_o);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready_o, rsp_valid_o, rsp_id_o, rsp_idx_o, rsp_evict_o, flush_busy_o, valid_o} !== 29'b0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got rv=%b idx=%0d ev=%b busy=%b valid=%h, want all 0",
                     rsp_valid_o, rsp_idx_o, rsp_evict_o, flush_busy_o, valid_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        exp = m_step(4'b0001);
        do_alloc(4'b0001, 0, 1'b0, 4'd0, 1'b0, obs, lat, stab, busy);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rstmid_alloc: got %b want %b", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_plru_evict();
        test_back_to_back_rr();
        test_inval_hit();
        test_flush();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
